// File: rtl/ofdm_rx_pkg.sv
// ---------------------------------------------------------------------------
// ofdm_rx_pkg
// Shared constants and types for the OFDM receive chain.
//   N_FFT / N_DATA / N_PILOT : FFT size, data and pilot subcarrier counts
//   PILOT_BIN_*              : FFT bin of each pilot (logical -21, -7, +7, +21)
//   sample_t                 : complex sample {im, re}, each half 5.11 signed
//   N_OUT                    : words emitted per symbol
// Build option: define PILOT_OUT_EN to append the four pilots to every symbol.
// ---------------------------------------------------------------------------
package ofdm_rx_pkg;

  localparam int N_FFT   = 64;
  localparam int N_DATA  = 48;
  localparam int N_PILOT = 4;

  localparam logic [5:0] PILOT_BIN_M21 = 6'd43;
  localparam logic [5:0] PILOT_BIN_M7  = 6'd57;
  localparam logic [5:0] PILOT_BIN_P7  = 6'd7;
  localparam logic [5:0] PILOT_BIN_P21 = 6'd21;

  typedef struct packed {
    logic [15:0] im;
    logic [15:0] re;
  } sample_t;

  localparam int SAMPLE_W = $bits(sample_t);

`ifdef PILOT_OUT_EN
  localparam int N_OUT = N_DATA + N_PILOT;
`else
  localparam int N_OUT = N_DATA;
`endif

endpackage

// File: rtl/sc_order_rom.sv
// ---------------------------------------------------------------------------
// sc_order_rom
// Combinational map from output index to FFT bin.
//   idx [5:0] : output position within a symbol
//   bin [5:0] : FFT bin to read for that position
// Indices 0..47 walk the data subcarriers -26..-1 then +1..+26 (pilots
// skipped); indices 48..51 give the pilot bins; anything else maps to bin 0.
// ---------------------------------------------------------------------------
module sc_order_rom
  import ofdm_rx_pkg::*;
(
  input  logic [5:0] idx,
  output logic [5:0] bin
);

  // Each data run is a contiguous bin range at a fixed offset from the index;
  // the offset steps by one after every skipped pilot and the negative half
  // lives in the top of the FFT (bins 38..63).
  always_comb begin
    bin = 6'd0;
    if (idx < 6'd5) begin
      bin = idx + 6'd38;
    end else if (idx < 6'd18) begin
      bin = idx + 6'd39;
    end else if (idx < 6'd24) begin
      bin = idx + 6'd40;
    end else if (idx < 6'd30) begin
      bin = idx - 6'd23;
    end else if (idx < 6'd43) begin
      bin = idx - 6'd22;
    end else if (idx < 6'(N_DATA)) begin
      bin = idx - 6'd21;
    end else if (idx < 6'(N_DATA + N_PILOT)) begin
      case (idx[1:0])
        2'd0:    bin = PILOT_BIN_M21;
        2'd1:    bin = PILOT_BIN_M7;
        2'd2:    bin = PILOT_BIN_P7;
        2'd3:    bin = PILOT_BIN_P21;
        default: bin = 6'd0;
      endcase
    end else begin
      bin = 6'd0;
    end
  end

endmodule

// File: rtl/subcarrier_demap.sv
// ---------------------------------------------------------------------------
// subcarrier_demap
// Buffers natural-order FFT bins into a two-bank ping-pong store and streams
// the data subcarriers out in logical order.
//   CLK_I, RST_I               : clock, synchronous active-high reset
//   DAT_I, CYC_I, STB_I, WE_I  : upstream sample write
//   ACK_O                      : sample accepted this cycle
//   DAT_O, CYC_O, STB_O, WE_O  : downstream subcarrier write (registered)
//   ACK_I                      : downstream accepts the current word
// Build option: PILOT_OUT_EN appends the four pilots after the 48 data words.
// ---------------------------------------------------------------------------
module subcarrier_demap
  import ofdm_rx_pkg::*;
#(
  parameter int DAT_W = SAMPLE_W  // 32: {Im[31:16], Re[15:0]}
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic [DAT_W-1:0] DAT_I,
  input  logic             CYC_I,
  input  logic             STB_I,
  input  logic             WE_I,
  output logic             ACK_O,
  output logic [DAT_W-1:0] DAT_O,
  output logic             CYC_O,
  output logic             STB_O,
  output logic             WE_O,
  input  logic             ACK_I
);

  logic [DAT_W-1:0] mem_r [0:1][0:N_FFT-1];
  logic [1:0]       full_r;
  logic             wr_bank_r;
  logic [5:0]       wr_cnt_r;
  logic             rd_bank_r;
  logic [5:0]       rd_idx_r;
  logic             out_bank_r;   // bank the word in the output register came from
  logic             out_last_r;   // output register holds that bank's final word
  logic [DAT_W-1:0] dat_r;
  logic             stb_r;
  logic             cyc_r;

  logic             accept_s;
  logic             wr_wrap_s;
  logic             out_free_s;
  logic             load_s;
  logic             rd_last_s;
  logic             release_s;
  logic [5:0]       rd_bin_s;
  logic [1:0]       full_nxt_s;

  sc_order_rom u_rom (
    .idx (rd_idx_r),
    .bin (rd_bin_s)
  );

  // Handshake decode for both sides of the buffer.
  always_comb begin
    accept_s   = CYC_I & STB_I & WE_I & ~full_r[wr_bank_r];
    wr_wrap_s  = accept_s & (wr_cnt_r == 6'd63);
    out_free_s = ~stb_r | ACK_I;
    // Reads only wait on the full flag: the pointer leaves a bank as soon as
    // its last word is loaded, so it never revisits a bank still draining.
    load_s     = out_free_s & full_r[rd_bank_r];
    rd_last_s  = (rd_idx_r == 6'(N_OUT - 1));
    release_s  = stb_r & ACK_I & out_last_r;
  end

  // Full flags: the freed bank and the newly filled bank are always different.
  always_comb begin
    full_nxt_s = full_r;
    for (int b = 0; b < 2; b++) begin
      full_nxt_s[b] = (full_r[b] & ~(release_s & (out_bank_r == 1'(b))))
                    | (wr_wrap_s & (wr_bank_r == 1'(b)));
    end
  end

  assign ACK_O = accept_s;
  assign DAT_O = dat_r;
  assign STB_O = stb_r;
  assign WE_O  = stb_r;
  assign CYC_O = cyc_r;

  // Sample storage; contents need no reset since the full flags gate reads.
  always_ff @(posedge CLK_I) begin
    if (accept_s) begin
      mem_r[wr_bank_r][wr_cnt_r] <= DAT_I;
    end
  end

  // Write side: bin counter, bank pointer, partial-symbol discard.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      wr_cnt_r  <= 6'd0;
      wr_bank_r <= 1'b0;
      full_r    <= 2'b00;
    end else begin
      full_r <= full_nxt_s;
      if (!CYC_I) begin
        wr_cnt_r <= 6'd0;
      end else if (accept_s) begin
        wr_cnt_r <= wr_cnt_r + 6'd1;
      end
      if (wr_wrap_s) begin
        wr_bank_r <= ~wr_bank_r;
      end
    end
  end

  // Read side: output register loads whenever it is empty or being taken.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      rd_idx_r   <= 6'd0;
      rd_bank_r  <= 1'b0;
      out_bank_r <= 1'b0;
      out_last_r <= 1'b0;
      dat_r      <= '0;
      stb_r      <= 1'b0;
      cyc_r      <= 1'b0;
    end else begin
      if (load_s) begin
        dat_r      <= mem_r[rd_bank_r][rd_bin_s];
        stb_r      <= 1'b1;
        cyc_r      <= 1'b1;
        out_bank_r <= rd_bank_r;
        out_last_r <= rd_last_s;
        if (rd_last_s) begin
          rd_idx_r  <= 6'd0;
          rd_bank_r <= ~rd_bank_r;
        end else begin
          rd_idx_r <= rd_idx_r + 6'd1;
        end
      end else if (out_free_s) begin
        stb_r      <= 1'b0;
        out_last_r <= 1'b0;
        // Nothing left to send and upstream has closed its cycle; any partial
        // symbol is being discarded this same cycle.
        if (!CYC_I) begin
          cyc_r <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_subcarrier_demap.sv
// ---------------------------------------------------------------------------
// tb_subcarrier_demap
// Directed bench for subcarrier_demap. Samples carry {tag*64+bin, bin} so
// words from different symbols are distinguishable; the expected output
// order is built independently from the subcarrier plan.
// Build option: PILOT_OUT_EN expects 52 words per symbol.
// ---------------------------------------------------------------------------
module tb_subcarrier_demap;

  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b1;
  logic [31:0] DAT_I = 32'd0;
  logic        CYC_I = 1'b0;
  logic        STB_I = 1'b0;
  logic        WE_I  = 1'b0;
  logic        ACK_O;
  logic [31:0] DAT_O;
  logic        CYC_O;
  logic        STB_O;
  logic        WE_O;
  logic        ACK_I = 1'b1;

  int          errors = 0;
  int          checks = 0;
  int          order[$];
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  int          chk_idx = 0;
  int          cyc_cnt = 0;
  bit          watch_frz = 1'b0;
  bit          frz_bad = 1'b0;
  logic [31:0] frz_dat = 32'd0;

  subcarrier_demap dut (
    .CLK_I (CLK_I),
    .RST_I (RST_I),
    .DAT_I (DAT_I),
    .CYC_I (CYC_I),
    .STB_I (STB_I),
    .WE_I  (WE_I),
    .ACK_O (ACK_O),
    .DAT_O (DAT_O),
    .CYC_O (CYC_O),
    .STB_O (STB_O),
    .WE_O  (WE_O),
    .ACK_I (ACK_I)
  );

  always #5 CLK_I = ~CLK_I;

  always @(posedge CLK_I) cyc_cnt <= cyc_cnt + 1;

  // Record every word the sink takes (taken at the following rising edge).
  always @(negedge CLK_I) begin
    if (RST_I === 1'b0 && STB_O === 1'b1 && ACK_I === 1'b1) got_q.push_back(DAT_O);
  end

  // Flag any movement of the output while the sink is stalled.
  always @(negedge CLK_I) begin
    if (watch_frz && (STB_O !== 1'b1 || DAT_O !== frz_dat)) frz_bad <= 1'b1;
  end

  function automatic logic [31:0] mk(input int tag, input int bin);
    logic [15:0] hi;
    logic [15:0] lo;
    hi = 16'(tag * 64 + bin);
    lo = 16'(bin);
    return {hi, lo};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  task automatic put_sample(input int tag, input int bin, output int waits);
    int w;
    w = 0;
    DAT_I = mk(tag, bin);
    CYC_I = 1'b1;
    STB_I = 1'b1;
    WE_I  = 1'b1;
    @(negedge CLK_I);
    while (ACK_O !== 1'b1 && w < 400) begin
      @(negedge CLK_I);
      w++;
    end
    if (ACK_O !== 1'b1) begin
      chk("ack_timeout", 32'(ACK_O), 32'd1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "FAIL ack_timeout: input never accepted");
    end
    waits = w;
    @(posedge CLK_I);
    #1;
  endtask

  task automatic go_idle();
    CYC_I = 1'b0;
    STB_I = 1'b0;
    WE_I  = 1'b0;
  endtask

  task automatic send_symbol(input int tag, input int n, output int stalls);
    int w;
    stalls = 0;
    for (int b = 0; b < n; b++) begin
      put_sample(tag, b, w);
      stalls += w;
    end
  endtask

  task automatic add_exp(input int tag, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(mk(tag, order[i]));
  endtask

  task automatic wait_out(input int n);
    int k;
    k = 0;
    while (got_q.size() < n && k < 1000) begin
      @(posedge CLK_I);
      #1;
      k++;
    end
    chk("out_timeout", 32'(got_q.size() >= n), 32'd1);
    repeat (8) @(posedge CLK_I);
    #1;
  endtask

  task automatic compare_out(input string tag);
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = chk_idx; i < exp_q.size() && i < got_q.size(); i++) begin
      chk({tag, "_word"}, got_q[i], exp_q[i]);
    end
    chk_idx = exp_q.size();
  endtask

  initial begin
    int  st;
    int  g0;
    int  g1;
    int  n;
    int  c0;
    bit  ack_seen;

    for (int b = 38; b < 64; b++) if (b != 43 && b != 57) order.push_back(b);
    for (int b = 1; b < 27; b++) if (b != 7 && b != 21) order.push_back(b);
`ifdef PILOT_OUT_EN
    order.push_back(43);
    order.push_back(57);
    order.push_back(7);
    order.push_back(21);
`endif

    // Reset state
    repeat (2) @(posedge CLK_I);
    #1;
    RST_I = 1'b0;
    @(negedge CLK_I);
    chk("rst_dat", DAT_O, 32'd0);
    chk("rst_stb", 32'(STB_O), 32'd0);
    chk("rst_cyc", 32'(CYC_O), 32'd0);
    chk("rst_we", 32'(WE_O), 32'd0);
    @(posedge CLK_I);
    #1;

    // One symbol, sink always ready: order, count and 2-cycle latency
    send_symbol(0, 64, st);
    go_idle();
    @(negedge CLK_I);
    chk("stb_early", 32'(STB_O), 32'd0);
    @(negedge CLK_I);
    chk("stb_2cyc", 32'(STB_O), 32'd1);
    chk("we_eq_stb", 32'(WE_O), 32'd1);
    chk("cyc_on", 32'(CYC_O), 32'd1);
    chk("first_word", DAT_O, 32'h0026_0026);
    add_exp(0, order.size());
    wait_out(exp_q.size());
    compare_out("sym1");
    chk("cyc_off", 32'(CYC_O), 32'd0);

    // Four back-to-back symbols, no input stall after the first
    send_symbol(1, 64, st);
    n = 0;
    for (int t = 2; t <= 4; t++) begin
      send_symbol(t, 64, st);
      n += st;
    end
    go_idle();
    chk("b2b_stalls", 32'(n), 32'd0);
    for (int t = 1; t <= 4; t++) add_exp(t, order.size());
    wait_out(exp_q.size());
    compare_out("b2b");

    // Sink stalled 200 cycles during a symbol's output
    g0 = got_q.size();
    send_symbol(9, 64, st);
    go_idle();
    n = 0;
    while (got_q.size() < g0 + 10 && n < 200) begin
      @(posedge CLK_I);
      #1;
      n++;
    end
    ACK_I = 1'b0;
    frz_dat = DAT_O;
    watch_frz = 1'b1;
    c0 = cyc_cnt;
    send_symbol(10, 64, st);
    DAT_I = mk(11, 0);
    CYC_I = 1'b1;
    STB_I = 1'b1;
    WE_I  = 1'b1;
    ack_seen = 1'b0;
    while (cyc_cnt - c0 < 200) begin
      @(negedge CLK_I);
      if (ACK_O === 1'b1) ack_seen = 1'b1;
      @(posedge CLK_I);
      #1;
    end
    watch_frz = 1'b0;
    chk("both_full_ack", 32'(ack_seen), 32'd0);
    chk("frozen", 32'(frz_bad), 32'd0);
    chk("frz_stb", 32'(STB_O), 32'd1);
    chk("frz_dat", DAT_O, frz_dat);
    ACK_I = 1'b1;
    g1 = got_q.size();
    n = 0;
    fork
      begin
        send_symbol(11, 64, st);
        go_idle();
      end
      begin
        while (got_q.size() < g0 + 2 * order.size() && n < 400) begin
          @(posedge CLK_I);
          #1;
          n++;
        end
      end
    join
    chk("no_gap", 32'(n), 32'(g0 + 2 * order.size() - g1));
    for (int t = 9; t <= 11; t++) add_exp(t, order.size());
    wait_out(exp_q.size());
    compare_out("stall");

    // Partial symbol abandoned by CYC_I, then a full one
    send_symbol(12, 30, st);
    go_idle();
    repeat (3) @(posedge CLK_I);
    #1;
    send_symbol(13, 64, st);
    go_idle();
    add_exp(13, order.size());
    wait_out(exp_q.size());
    compare_out("partial");

    // Reset during output at word 20, then a fresh symbol
    g0 = got_q.size();
    send_symbol(14, 64, st);
    go_idle();
    n = 0;
    while (got_q.size() < g0 + 20 && n < 200) begin
      @(posedge CLK_I);
      #1;
      n++;
    end
    RST_I = 1'b1;
    @(posedge CLK_I);
    #1;
    RST_I = 1'b0;
    @(negedge CLK_I);
    chk("mid_rst_stb", 32'(STB_O), 32'd0);
    chk("mid_rst_cyc", 32'(CYC_O), 32'd0);
    chk("mid_rst_dat", DAT_O, 32'd0);
    chk("mid_rst_ack", 32'(ACK_O), 32'd0);
    @(posedge CLK_I);
    #1;
    add_exp(14, 20);
    send_symbol(15, 64, st);
    go_idle();
    add_exp(15, order.size());
    wait_out(exp_q.size());
    compare_out("reset");
    chk("end_cyc", 32'(CYC_O), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
